// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: holds NZCV, evaluates Cond, gates PCS/RegW/MemW.
// Optional saturating exec/squash counters are built when COND_PERF_CNT_EN is defined.
module cond_flag_unit #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
`ifdef COND_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       InstrValid,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
`ifdef COND_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
`endif
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_RS = 4'b1111
    } cond_e;

    logic [3:0] flags_q, flags_d;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Evaluated against the registered (pre-update) flags. Unknown or
    // reserved codes fall to the default and squash.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = ~flag_v;
            COND_HI: cond_pass = flag_c & ~flag_z;
            COND_LS: cond_pass = ~flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            COND_AL: cond_pass = 1'b1;
            COND_RS: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

    // Holding reset_n low also blocks every write enable, so garbage on
    // Cond during reset can never reach the PC, register file or memory.
    assign CondEx   = InstrValid & reset_n & cond_pass;
    assign PCSrc    = PCS  & CondEx;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && CondEx) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && CondEx) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= FLAG_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Bubbles (InstrValid=0) are neither executed nor squashed.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (InstrValid && CondEx) begin
            if (exec_cnt_q != '1) begin
                exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end
        end else if (InstrValid) begin
            if (squash_cnt_q != '1) begin
                squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ExecCount   = exec_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit; counter scenarios build only with COND_PERF_CNT_EN.
module tb_cond_flag_unit;

    logic       clk;
    logic       reset_n;
    logic       InstrValid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [3:0] ExecCount;
    logic [3:0] SquashCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected {CondEx, PCSrc, RegWrite, MemWrite, Flags} per driven cycle.
    logic [7:0] exp_q[$];
    logic [7:0] cnt_q[$];

    // Reference state for the flag register and counters.
    logic [3:0] mf;
    int         m_exec;
    int         m_sq;

    cond_flag_unit #(
        .FLAG_RESET(4'b0000)
`ifdef COND_PERF_CNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .InstrValid (InstrValid),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
        .Flags      (Flags)
`ifdef COND_PERF_CNT_EN
        ,
        .ExecCount  (ExecCount),
        .SquashCount(SquashCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input logic v, input logic [3:0] c,
                              input logic [3:0] alu, input logic [1:0] fw);
        logic p;
        if (!reset_n) begin
            mf     = 4'b0000;
            m_exec = 0;
            m_sq   = 0;
        end else begin
            p = v && cond_ref(c, mf);
            if (v && p)  m_exec = (m_exec < 15) ? m_exec + 1 : 15;
            if (v && !p) m_sq   = (m_sq   < 15) ? m_sq   + 1 : 15;
            if (p && fw[1]) mf[3:2] = alu[3:2];
            if (p && fw[0]) mf[1:0] = alu[1:0];
        end
    endtask

    // Drives one instruction at posedge+1, compares at the following negedge,
    // then advances to just past the next posedge.
    task automatic cycle(input string name, input logic v, input logic [3:0] c,
                         input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic [7:0] exp);
        logic [7:0] got;
        logic [7:0] e;
        InstrValid = v;
        Cond       = c;
        ALUFlags   = alu;
        FlagW      = fw;
        PCS        = pcs;
        RegW       = regw;
        MemW       = memw;
        exp_q.push_back(exp);
        @(negedge clk);
        got = {CondEx, PCSrc, RegWrite, MemWrite, Flags};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got {cx,pc,rw,mw,nzcv}=%b expected %b", name, got, e);
        end
        model_step(v, c, alu, fw);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        InstrValid = 1'b0;
        Cond       = 4'h0;
        ALUFlags   = 4'h0;
        FlagW      = 2'b00;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mf      = 4'b0000;
        m_exec  = 0;
        m_sq    = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset_gates_al", 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 8'h00);
        reset_n = 1'b1;
        cycle("reset_eq_fails", 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle("reset_al_regw",  1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 8'hA0);
    endtask

    task automatic test_flag_update();
        cycle("upd_same_cycle", 1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 8'h80);
        cycle("upd_eq_pcs",     1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 8'hC4);
        cycle("upd_ne_pcs",     1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h04);
    endtask

    task automatic test_squash();
        do_reset();
        cycle("sq_no_update",   1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle("sq_flags_held",  1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h90);
    endtask

    task automatic test_partial_update();
        cycle("part_nz",        1'b1, 4'hE, 4'hB, 2'b10, 1'b0, 1'b0, 1'b0, 8'h80);
        cycle("part_cv",        1'b1, 4'hE, 4'h3, 2'b01, 1'b0, 1'b0, 1'b0, 8'h88);
        cycle("part_result",    1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h8B);
    endtask

    task automatic test_conditions();
        cycle("set_1001",       1'b1, 4'hE, 4'h1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h8B);
        cycle("ge_pass",        1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h89);
        cycle("gt_pass",        1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h89);
        cycle("lt_fail",        1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h09);
        cycle("le_fail",        1'b1, 4'hD, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h09);
        cycle("set_1000",       1'b1, 4'hE, 4'h0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h89);
        cycle("lt_pass",        1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h88);
        cycle("hi_fail",        1'b1, 4'h8, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h08);
        cycle("reserved_sq",    1'b1, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 8'h08);
        cycle("invalid_al",     1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 8'h08);
        cycle("after_invalid",  1'b1, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h98);
    endtask

    task automatic test_back_to_back();
        logic       v, pcs, regw, memw, p;
        logic [3:0] c, alu;
        logic [1:0] fw;
        for (int i = 0; i < 60; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            c    = 4'($urandom_range(0, 15));
            alu  = 4'($urandom_range(0, 15));
            fw   = 2'($urandom_range(0, 3));
            pcs  = 1'($urandom_range(0, 1));
            regw = 1'($urandom_range(0, 1));
            memw = 1'($urandom_range(0, 1));
            p    = v && cond_ref(c, mf);
            cycle($sformatf("rand_%0d", i), v, c, alu, fw, pcs, regw, memw,
                  {p, pcs & p, regw & p, memw & p, mf});
        end
    endtask

`ifdef COND_PERF_CNT_EN
    task automatic check_counts(input string name);
        logic [7:0] e;
        cnt_q.push_back({4'(m_exec), 4'(m_sq)});
        e = cnt_q.pop_front();
        checks++;
        if ({ExecCount, SquashCount} !== e) begin
            failures++;
            $display("FAIL %s: got exec=%0d squash=%0d expected exec=%0d squash=%0d",
                     name, ExecCount, SquashCount, e[7:4], e[3:0]);
        end
    endtask

    task automatic test_perf_cnt();
        do_reset();
        check_counts("cnt_after_reset");
        for (int i = 0; i < 3; i++)
            cycle("cnt_exec", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 2; i++)
            cycle("cnt_sq", 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle("cnt_bubble", 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_counts("cnt_3_2");
        if (m_exec != 3 || m_sq != 2) begin
            failures++;
            $display("FAIL cnt_model: model exec=%0d squash=%0d expected 3 and 2", m_exec, m_sq);
        end
        cycle("cnt_exec_more", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h80);
        reset_n = 1'b0;
        cycle("cnt_in_reset", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_counts("cnt_mid_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++)
            cycle("cnt_sat_exec", 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h80);
        check_counts("cnt_exec_sat");
        for (int i = 0; i < 17; i++)
            cycle("cnt_sat_sq", 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_counts("cnt_both_sat");
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_flag_update();
        test_squash();
        test_partial_update();
        test_conditions();
        test_back_to_back();
`ifdef COND_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
